// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 64 B, 16-bit registered data memory.
// Optional misaligned-halfword check enabled by defining DMEM_ARB_ALIGN_CHK_EN.
//
// state  | meaning
// IDLE   | waiting for a request, winner picked on the edge
// ACCESS | latched fields on mem_*, gnt high, memory acts on exit edge
// RESP   | mem_dout valid, rdata/done loaded on exit edge
module dmem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_size,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_size,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_wmem,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_memc,
  input  logic [DATA_W-1:0] mem_dout,
`ifdef DMEM_ARB_ALIGN_CHK_EN
  output logic              m0_err,
  output logic              m1_err,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              port_q, port_d, we_q, we_d, size_q, size_d, last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              win, misal;
`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic              err0_q, err0_d, err1_q, err1_d;

  assign misal = size_q & addr_q[0];
`else
  assign misal = 1'b0;
`endif

  // win = 1 selects port 1; round-robin favours the port not granted last
  always_comb begin
    if (PRIO_MODE == 1)         win = ~m0_req;
    else if (m0_req && m1_req)  win = ~last_q;
    else                        win = ~m0_req;
  end

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    last_d   = last_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    err0_d   = 1'b0;
    err1_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          port_d  = win;
          last_d  = win;
          we_d    = win ? m1_we    : m0_we;
          size_d  = win ? m1_size  : m0_size;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (port_q) begin
          done1_d = 1'b1;
          if (!we_q && !misal) rdata1_d = mem_dout;
        end else begin
          done0_d = 1'b1;
          if (!we_q && !misal) rdata0_d = mem_dout;
        end
`ifdef DMEM_ARB_ALIGN_CHK_EN
        err0_d = ~port_q & misal;
        err1_d = port_q & misal;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_q   <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
`ifdef DMEM_ARB_ALIGN_CHK_EN
      err0_q   <= err0_d;
      err1_q   <= err1_d;
`endif
    end
  end

  // rst gates the strobe directly so a reset in ACCESS stops the write
  assign mem_wmem = (state_q == ACCESS) & we_q & ~rst & ~misal;
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
  assign mem_memc = size_q;
  assign m0_gnt   = (state_q == ACCESS) & ~port_q;
  assign m1_gnt   = (state_q == ACCESS) & port_q;
  assign m0_done  = done0_q;
  assign m1_done  = done1_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign busy     = (state_q != IDLE);
`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign m0_err   = err0_q;
  assign m1_err   = err1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a big-endian 64 B memory model.
// Expectations for misaligned halfwords follow DMEM_ARB_ALIGN_CHK_EN.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
`ifdef DMEM_ARB_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m0_size, m0_gnt, m0_done;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_size, m1_gnt, m1_done;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_wmem, mem_memc, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          m0_err, m1_err;

  logic          p_m0_req, p_m1_req, p_m0_gnt, p_m1_gnt, p_m0_done, p_m1_done;
  logic          p_wmem, p_memc, p_busy, p_m0_err, p_m1_err;
  logic [AW-1:0] p_addr_c, p_mem_addr;
  logic [DW-1:0] p_data_c, p_m0_rdata, p_m1_rdata, p_mem_din, p_mem_dout;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .mem_wmem(mem_wmem), .mem_addr(mem_addr), .mem_din(mem_din), .mem_memc(mem_memc),
    .mem_dout(mem_dout),
`ifdef DMEM_ARB_ALIGN_CHK_EN
    .m0_err(m0_err), .m1_err(m1_err),
`endif
    .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) u_dut_prio (
    .clk(clk), .rst(rst),
    .m0_req(p_m0_req), .m0_we(1'b0), .m0_size(1'b1), .m0_addr(p_addr_c), .m0_wdata(p_data_c),
    .m0_gnt(p_m0_gnt), .m0_done(p_m0_done), .m0_rdata(p_m0_rdata),
    .m1_req(p_m1_req), .m1_we(1'b0), .m1_size(1'b1), .m1_addr(p_addr_c), .m1_wdata(p_data_c),
    .m1_gnt(p_m1_gnt), .m1_done(p_m1_done), .m1_rdata(p_m1_rdata),
    .mem_wmem(p_wmem), .mem_addr(p_mem_addr), .mem_din(p_mem_din), .mem_memc(p_memc),
    .mem_dout(p_mem_dout),
`ifdef DMEM_ARB_ALIGN_CHK_EN
    .m0_err(p_m0_err), .m1_err(p_m1_err),
`endif
    .busy(p_busy)
  );

  // memory: big-endian halfwords, halfword aligns down, byte reads zero-extend
  logic [7:0] mem [64];
  logic [5:0] mem_a;
  always @(posedge clk) begin
    mem_a = mem_addr[5:0];
    if (mem_memc) begin
      mem_a[0] = 1'b0;
      mem_dout <= {mem[mem_a], mem[mem_a + 6'd1]};
    end else begin
      mem_dout <= {8'h00, mem[mem_a]};
    end
    if (mem_wmem) begin
      if (mem_memc) begin
        mem[mem_a]        = mem_din[15:8];
        mem[mem_a + 6'd1] = mem_din[7:0];
      end else begin
        mem[mem_a] = mem_din[7:0];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {bit port; logic [15:0] rdata; bit err;} done_t;
  done_t       done_q[$];
  bit          gnt_q[$];
  bit          pgnt_q[$];
  logic [15:0] last_rd [2];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string what);
    checks++;
    errors++;
    $display("FAIL %s actual=%s", nm, what);
  endtask

  done_t mon_e;
  bit    mon_g;
  always @(negedge clk) begin
    if (m0_gnt && m1_gnt) fail("gnt_both", "two grants");
    else if (m0_gnt || m1_gnt) begin
      if (gnt_q.size() == 0) fail("gnt_unexpected", "grant with empty queue");
      else begin
        mon_g = gnt_q.pop_front();
        chk("gnt_port", {31'd0, m1_gnt}, {31'd0, mon_g});
      end
    end
    if (m0_done && m1_done) fail("done_both", "two dones");
    else if (m0_done || m1_done) begin
      if (done_q.size() == 0) fail("done_unexpected", "done with empty queue");
      else begin
        mon_e = done_q.pop_front();
        chk("done_port", {31'd0, m1_done}, {31'd0, mon_e.port});
        chk("rdata", {16'd0, (m1_done ? m1_rdata : m0_rdata)}, {16'd0, mon_e.rdata});
`ifdef DMEM_ARB_ALIGN_CHK_EN
        chk("err", {31'd0, (m1_done ? m1_err : m0_err)}, {31'd0, mon_e.err});
`endif
      end
    end
    if (p_m0_gnt || p_m1_gnt) begin
      if (pgnt_q.size() == 0) fail("prio_gnt_unexpected", "grant with empty queue");
      else begin
        mon_g = pgnt_q.pop_front();
        chk("prio_gnt_port", {31'd0, p_m1_gnt}, {31'd0, mon_g});
      end
    end
  end

  task automatic set_port(input bit p, input bit we, input bit sz, input logic [15:0] a,
                          input logic [15:0] wd);
    if (p) begin m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = wd; end
    else   begin m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = wd; end
  endtask

  task automatic set_req(input bit p, input bit v);
    if (p) m1_req = v; else m0_req = v;
  endtask

  task automatic wait_gnt(input bit p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p ? m1_gnt : m0_gnt) begin ok = 1'b1; break; end
    end
    if (!ok) fail("gnt_timeout", "no grant within 20 cycles");
  endtask

  task automatic wait_done(input bit p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p ? m1_done : m0_done) begin ok = 1'b1; break; end
    end
    if (!ok) fail("done_timeout", "no done within 20 cycles");
  endtask

  task automatic push_exp(input bit p, input bit we, input bit err, input logic [15:0] rd);
    logic [15:0] r;
    if (we || err) r = last_rd[p];
    else begin r = rd; last_rd[p] = rd; end
    gnt_q.push_back(p);
    done_q.push_back('{port: p, rdata: r, err: err});
  endtask

  task automatic do_access(input bit p, input bit we, input bit sz, input logic [15:0] a,
                           input logic [15:0] wd, input logic [15:0] rd, input bit err);
    bit ok;
    int t0;
    set_port(p, we, sz, a, wd);
    push_exp(p, we, err, rd);
    set_req(p, 1'b1);
    t0 = cyc;
    wait_gnt(p, ok);
    set_req(p, 1'b0);
    if (ok) begin
      wait_done(p, ok);
      if (ok) chk("latency", cyc - t0, 32'd3);
    end
  endtask

  task automatic run_tie(input bit first);
    bit ok;
    set_port(1'b0, 1'b0, 1'b1, 16'h0004, 16'h0000);
    set_port(1'b1, 1'b0, 1'b1, 16'h0006, 16'h0000);
    push_exp(first, 1'b0, 1'b0, first ? 16'h003C : 16'hA55A);
    push_exp(!first, 1'b0, 1'b0, first ? 16'hA55A : 16'h003C);
    m0_req = 1'b1;
    m1_req = 1'b1;
    wait_gnt(first, ok);
    set_req(first, 1'b0);
    wait_gnt(!first, ok);
    set_req(!first, 1'b0);
    wait_done(!first, ok);
  endtask

  initial begin
    bit ok;
    int seen;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem_dout = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    m0_req = 0; m1_req = 0; p_m0_req = 0; p_m1_req = 0;
    p_addr_c = 16'h0000; p_data_c = 16'h0000; p_mem_dout = 16'h0000;
    set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_done", {30'd0, m1_done, m0_done}, 32'd0);
    chk("rst_wmem", {31'd0, mem_wmem}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", {16'd0, mem_din}, 32'd0);
    chk("rst_memc", {31'd0, mem_memc}, 32'd0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 32'd0);
    rst = 1'b0;

    do_access(1'b0, 1'b1, 1'b1, 16'h0004, 16'hA55A, 16'h0000, 1'b0);
    do_access(1'b0, 1'b0, 1'b1, 16'h0004, 16'h0000, 16'hA55A, 1'b0);

    do_access(1'b1, 1'b1, 1'b0, 16'h0007, 16'hAB3C, 16'h0000, 1'b0);
    do_access(1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000, 16'h003C, 1'b0);
    do_access(1'b1, 1'b0, 1'b1, 16'h0006, 16'h0000, 16'h003C, 1'b0);

    run_tie(1'b0);
    run_tie(1'b0);
    do_access(1'b0, 1'b0, 1'b1, 16'h0004, 16'h0000, 16'hA55A, 1'b0);
    run_tie(1'b1);

    // port 0 raises and drops req while port 1 is in flight: never served
    set_port(1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000);
    push_exp(1'b1, 1'b0, 1'b0, 16'h003C);
    m1_req = 1'b1;
    wait_gnt(1'b1, ok);
    m1_req = 1'b0;
    set_port(1'b0, 1'b1, 1'b1, 16'h0020, 16'hDEAD);
    m0_req = 1'b1;
    @(negedge clk);
    m0_req = 1'b0;
    wait_done(1'b1, ok);
    repeat (6) @(negedge clk);
    chk("withdrawn_no_write", {mem[32], mem[33]}, 16'h0000);

    do_access(1'b0, 1'b1, 1'b1, 16'h0003, 16'h1234, 16'h0000, ALIGN_CHK);
    do_access(1'b0, 1'b0, 1'b1, 16'h0002, 16'h0000, ALIGN_CHK ? 16'h0000 : 16'h1234, 1'b0);

    // reset during the ACCESS cycle of a write
    set_port(1'b0, 1'b1, 1'b1, 16'h0010, 16'hFFFF);
    gnt_q.push_back(1'b0);
    m0_req = 1'b1;
    wait_gnt(1'b0, ok);
    m0_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_done", {31'd0, m0_done}, 32'd0);
    chk("post_rst_rdata", {m1_rdata, m0_rdata}, 32'd0);
    repeat (4) @(negedge clk);
    do_access(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 1'b0);

    // fixed priority: port 0 wins every time with both held
    for (int i = 0; i < 3; i++) pgnt_q.push_back(1'b0);
    p_m0_req = 1'b1;
    p_m1_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen < 3; i++) begin
      @(negedge clk);
      if (p_m0_gnt) seen++;
    end
    p_m0_req = 1'b0;
    p_m1_req = 1'b0;
    chk("prio_grants_seen", seen, 32'd3);
    repeat (6) @(negedge clk);

    chk("gnt_queue_empty", gnt_q.size(), 32'd0);
    chk("done_queue_empty", done_q.size(), 32'd0);
    chk("prio_queue_empty", pgnt_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
